// File: rtl/conv_window_reader.sv
// conv_window_reader: read-side window controller for the circular convolution pixel buffer.
// Optional stall_cnt output is enabled by defining CONV_WINDOW_READER_STALL_CNT_EN.
module conv_window_reader #(
  parameter int MEMORY_SIZE   = 24,
  parameter int READ_ADDR_LEN = 8,
  parameter int INPUT_PREC    = 8,
  parameter int STRIDE        = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [15:0]                               frame_len,
  input  logic                                      wr_en,
  output logic                                      wr_ready,
  output logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0]  read_addr,
  input  logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0]  read_data,
  output logic                                      win_valid,
  input  logic                                      win_ready,
  output logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0]  win_data,
  output logic                                      busy,
  output logic                                      done
`ifdef CONV_WINDOW_READER_STALL_CNT_EN
  ,
  output logic [15:0]                               stall_cnt
`endif
);
  localparam int AW = INPUT_PREC + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  if (!(STRIDE >= 1 && STRIDE <= READ_ADDR_LEN && READ_ADDR_LEN <= MEMORY_SIZE &&
        MEMORY_SIZE <= 2 ** INPUT_PREC)) begin : g_bad_params
    $error("conv_window_reader: need 1 <= STRIDE <= READ_ADDR_LEN <= MEMORY_SIZE <= 2**INPUT_PREC");
  end

  logic [1:0]                              r_state;
  logic [INPUT_PREC-1:0]                   r_base;
  logic [AW-1:0]                           r_fill;
  logic [15:0]                             r_pos;
  logic [15:0]                             r_len;
  logic                                    r_done;
  logic                                    r_win_valid;
  logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0] r_win_data;

  logic          w_start_acc;
  logic          w_wr_acc;
  logic          w_out_free;
  logic          w_room;
  logic          w_capture;
  logic          w_finish;
  logic [15:0]   w_rem;
  logic [AW-1:0] w_retire;
  logic [AW-1:0] w_base_sum;
  logic [1:0]    w_state_next;

  always_comb begin
    wr_ready     = r_fill < AW'(MEMORY_SIZE);
    w_start_acc  = r_state == S_IDLE && start && !r_done;
    w_wr_acc     = wr_en && wr_ready;
    w_out_free   = !r_win_valid || win_ready;
    w_room       = 17'(r_pos) + 17'(READ_ADDR_LEN) <= 17'(r_len);
    w_rem        = r_len - r_pos;
    w_capture    = r_state == S_RUN && w_room && r_fill >= AW'(READ_ADDR_LEN) && w_out_free;
    w_finish     = r_state == S_FLUSH && 32'(r_fill) >= 32'(w_rem) && w_out_free;
    // rem never exceeds fill when finishing, so the cast cannot lose bits
    w_retire     = w_capture ? AW'(STRIDE) : w_finish ? AW'(w_rem) : '0;
    w_base_sum   = {1'b0, r_base} + w_retire;
    w_state_next = r_state == S_IDLE ? (w_start_acc ? S_RUN : S_IDLE) :
                   r_state == S_RUN  ? (w_room ? S_RUN : S_FLUSH) :
                   (r_state == S_FLUSH && !w_finish) ? S_FLUSH : S_IDLE;
    win_valid    = r_win_valid;
    win_data     = r_win_data;
    busy         = r_state != S_IDLE;
    done         = r_done;
  end

  for (genvar i = 0; i < READ_ADDR_LEN; i++) begin : g_addr
    logic [AW-1:0] w_a;
    assign w_a = {1'b0, r_base} + AW'(i);
    assign read_addr[i] = w_a >= AW'(MEMORY_SIZE) ? INPUT_PREC'(w_a - AW'(MEMORY_SIZE))
                                                  : w_a[INPUT_PREC-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_fill      <= '0;
      r_pos       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_fill      <= r_fill + AW'(w_wr_acc) - w_retire;
      r_base      <= w_base_sum >= AW'(MEMORY_SIZE) ? INPUT_PREC'(w_base_sum - AW'(MEMORY_SIZE))
                                                    : w_base_sum[INPUT_PREC-1:0];
      r_done      <= w_finish;
      r_win_valid <= w_capture || (r_win_valid && !win_ready);
      if (w_capture) r_win_data <= read_data;
      if (w_start_acc) begin
        r_len <= frame_len;
        r_pos <= '0;
      end else if (w_capture) begin
        r_pos <= r_pos + 16'(STRIDE);
      end
    end
  end

`ifdef CONV_WINDOW_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cnt <= '0;
    else if (w_start_acc) r_stall_cnt <= '0;
    else if (r_win_valid && !win_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
